systolic_ctrl: RTL and testbench

Sequencer for the systolic-array top level. It drives the enable pins of the input, weight and output buffers and the array's write_weight_en for one tile. A tile is one weight load, one activation stream of num_rows rows, and one result drain. It sits between a host-side source/sink handshake and the buffer enable inputs, replacing hand-driven enables.

---
 rtl/systolic_ctrl_pkg.sv | 24 ++
 rtl/systolic_ctrl_if.sv | 23 ++
 rtl/ctrl_beat_counter.sv | 37 +++
 rtl/systolic_ctrl.sv | 152 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic-array tile sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StShiftW,
        StLoadA,
        StStream,
        StDrain,
        StDone
    } state_e;

    // Pipeline depth from first activation out to first valid result row.
    function automatic int unsigned lat_default(input int unsigned array_width);
        return 2 * array_width - 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_rows,
                                              input int unsigned lat);
        return $clog2(max_rows + lat + 1);
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host-side beat handshake: source beats in, result rows out.
interface systolic_ctrl_if;

    logic src_valid;
    logic src_ready;
    logic res_valid;
    logic res_ready;

    modport master (
        output src_valid,
        output res_ready,
        input  src_ready,
        input  res_valid
    );

    modport slave (
        input  src_valid,
        input  res_ready,
        output src_ready,
        output res_valid
    );

endinterface

// File: rtl/ctrl_beat_counter.sv
// Shared beat counter: clear has priority over increment; last flags cnt == limit-1.
module ctrl_beat_counter #(
    parameter int unsigned CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == limit - CW'(1));

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer: weight load, weight shift, activation load, stream, drain, done.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned ARRAYWIDTH = 4,
    parameter int unsigned MAX_ROWS   = 64,
    parameter int unsigned LAT        = lat_default(ARRAYWIDTH),
    parameter int unsigned CW         = cnt_width(MAX_ROWS, LAT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   num_rows,
    input  logic            abort,
    systolic_ctrl_if.slave  host,
    output logic            busy,
    output logic            done,
    output logic            weight_buffer_load_en,
    output logic            weight_buffer_out_en,
    output logic            write_weight_en,
    output logic            input_buffer_load_en,
    output logic            input_buffer_out_en,
    output logic            output_buffer_load_en,
    output logic            output_buffer_out_en
);

    localparam logic [CW-1:0] AwC      = CW'(ARRAYWIDTH);
    localparam logic [CW-1:0] LatC     = CW'(LAT);
    localparam logic [CW-1:0] MaxRowsC = CW'(MAX_ROWS);

    state_e        state_q, state_d;
    logic [CW-1:0] rows_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic          inc;
    logic          clr;
    logic          last;
    logic          start_ok;

    assign start_ok = start && (num_rows != '0) && (num_rows <= MaxRowsC);

    ctrl_beat_counter #(
        .CW(CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc),
        .limit(limit),
        .cnt  (cnt),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        limit   = '0;
        inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = StLoadW;
            end
            StLoadW: begin
                limit = AwC;
                inc   = host.src_valid;
                if (inc && last) state_d = StShiftW;
            end
            StShiftW: begin
                limit = AwC;
                inc   = 1'b1;
                if (last) state_d = StLoadA;
            end
            StLoadA: begin
                limit = rows_q;
                inc   = host.src_valid;
                if (inc && last) state_d = StStream;
            end
            StStream: begin
                limit = rows_q + LatC;
                inc   = 1'b1;
                if (last) state_d = StDrain;
            end
            StDrain: begin
                limit = rows_q;
                inc   = host.res_ready;
                if (inc && last) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort overrides any transition chosen above.
        if (abort && (state_q != StIdle)) state_d = StIdle;
    end

    // Every state change restarts the shared counter.
    assign clr = (state_d != state_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && start_ok) rows_q <= num_rows;
        end
    end

    always_comb begin
        host.src_ready        = 1'b0;
        host.res_valid        = 1'b0;
        busy                  = (state_q != StIdle);
        done                  = 1'b0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;
        unique case (state_q)
            StLoadW: begin
                host.src_ready        = 1'b1;
                weight_buffer_load_en = host.src_valid;
            end
            StShiftW: begin
                weight_buffer_out_en = 1'b1;
                write_weight_en      = 1'b1;
            end
            StLoadA: begin
                host.src_ready       = 1'b1;
                input_buffer_load_en = host.src_valid;
            end
            StStream: begin
                input_buffer_out_en   = (cnt < rows_q);
                output_buffer_load_en = (cnt >= LatC);
            end
            StDrain: begin
                host.res_valid       = 1'b1;
                output_buffer_out_en = host.res_ready;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: table of tiles against a schedule scoreboard.
module tb_systolic_ctrl;
    import systolic_ctrl_pkg::*;

    localparam int unsigned AW   = 4;
    localparam int unsigned MAXR = 64;
    localparam int unsigned LATV = lat_default(AW);
    localparam int unsigned CWV  = cnt_width(MAXR, LATV);

    // Expected-vector bit layout.
    localparam logic [10:0] M_BUSY = 11'b100_0000_0000;
    localparam logic [10:0] M_DONE = 11'b010_0000_0000;
    localparam logic [10:0] M_SRDY = 11'b001_0000_0000;
    localparam logic [10:0] M_RVAL = 11'b000_1000_0000;
    localparam logic [10:0] M_WBL  = 11'b000_0100_0000;
    localparam logic [10:0] M_WBO  = 11'b000_0010_0000;
    localparam logic [10:0] M_WWE  = 11'b000_0001_0000;
    localparam logic [10:0] M_IBL  = 11'b000_0000_1000;
    localparam logic [10:0] M_IBO  = 11'b000_0000_0100;
    localparam logic [10:0] M_OBL  = 11'b000_0000_0010;
    localparam logic [10:0] M_OBO  = 11'b000_0000_0001;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [CWV-1:0] num_rows;
    logic           abort;
    logic           busy, done;
    logic           wbl, wbo, wwe, ibl, ibo, obl, obo;

    systolic_ctrl_if bus ();

    systolic_ctrl #(
        .ARRAYWIDTH(AW),
        .MAX_ROWS  (MAXR)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_rows             (num_rows),
        .abort                (abort),
        .host                 (bus),
        .busy                 (busy),
        .done                 (done),
        .weight_buffer_load_en(wbl),
        .weight_buffer_out_en (wbo),
        .write_weight_en      (wwe),
        .input_buffer_load_en (ibl),
        .input_buffer_out_en  (ibo),
        .output_buffer_load_en(obl),
        .output_buffer_out_en (obo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           start;
        logic [CWV-1:0] nrows;
        logic           sv;
        logic           rr;
        logic           abort;
        logic [10:0]    exp;
    } beat_t;

    typedef struct {
        int rows;
        bit gap;
        int hold_s;
        int hold_l;
        int busy_c;
        int abort_c;
        int done_c;
        int nw;
        int na;
        int no;
    } vec_t;

    beat_t sb[$];
    vec_t  cur;
    vec_t  vecs[8];
    int    gen_c;
    bit    gen_stop;
    int    tests = 0;
    int    fails = 0;

    function automatic logic [10:0] dut_vec();
        return {busy, done, bus.src_ready, bus.res_valid, wbl, wbo, wwe, ibl, ibo, obl, obo};
    endfunction

    function automatic logic sv_at(input int c);
        return (!cur.gap) || (c % 2 == 0);
    endfunction

    function automatic logic rr_at(input int c);
        return !((c >= cur.hold_s) && (c < cur.hold_s + cur.hold_l));
    endfunction

    task automatic check_vec(input string name, input int c, input logic [10:0] got,
                             input logic [10:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: outputs %b, expected %b", name, c, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Pushes one cycle of stimulus plus its expected outputs onto the scoreboard.
    task automatic push(input logic [10:0] e);
        beat_t b;
        if (gen_stop) return;
        b.start = (gen_c == 0) || (gen_c == cur.busy_c);
        b.nrows = (gen_c == 0) ? CWV'(cur.rows) : CWV'(5);
        b.sv    = sv_at(gen_c);
        b.rr    = rr_at(gen_c);
        b.abort = (gen_c == cur.abort_c);
        b.exp   = e;
        sb.push_back(b);
        if (b.abort) gen_stop = 1'b1;
        gen_c++;
    endtask

    task automatic gen_tile();
        int   acc;
        logic v;
        gen_c    = 0;
        gen_stop = 1'b0;
        push('0);
        acc = 0;
        while (acc < int'(AW) && !gen_stop) begin
            v = sv_at(gen_c);
            push(M_BUSY | M_SRDY | (v ? M_WBL : 11'd0));
            if (v) acc++;
        end
        for (int k = 0; k < int'(AW); k++) push(M_BUSY | M_WBO | M_WWE);
        acc = 0;
        while (acc < cur.rows && !gen_stop) begin
            v = sv_at(gen_c);
            push(M_BUSY | M_SRDY | (v ? M_IBL : 11'd0));
            if (v) acc++;
        end
        for (int k = 0; k < cur.rows + int'(LATV); k++) begin
            push(M_BUSY | ((k < cur.rows) ? M_IBO : 11'd0) | ((k >= int'(LATV)) ? M_OBL : 11'd0));
        end
        acc = 0;
        while (acc < cur.rows && !gen_stop) begin
            v = rr_at(gen_c);
            push(M_BUSY | M_RVAL | (v ? M_OBO : 11'd0));
            if (v) acc++;
        end
        push(M_BUSY | M_DONE);
        gen_stop = 1'b0;
        push('0);
        push('0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        beat_t       e;
        logic [10:0] got;
        int          c, done_c, nw, na, no;
        cur = v;
        gen_tile();
        c = 0; done_c = -1; nw = 0; na = 0; no = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            start         = e.start;
            num_rows      = e.nrows;
            bus.src_valid = e.sv;
            bus.res_ready = e.rr;
            abort         = e.abort;
            @(negedge clk);
            got = dut_vec();
            check_vec(name, c, got, e.exp);
            if (done && done_c < 0) done_c = c;
            if (wbl) nw++;
            if (ibl) na++;
            if (obo) no++;
            c++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check_int({name, " done cycle"}, done_c, v.done_c);
        check_int({name, " weight loads"}, nw, v.nw);
        check_int({name, " act loads"}, na, v.na);
        check_int({name, " result reads"}, no, v.no);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // rows, gap, hold_s, hold_l, busy_c, abort_c, done_c, nw, na, no
        vecs[0] = '{3, 1'b0, -1, 0, -1, -1, 25, 4, 3, 3};
        vecs[1] = '{3, 1'b1, -1, 0, -1, -1, 32, 4, 3, 3};
        vecs[2] = '{3, 1'b0, 23, 5, -1, -1, 30, 4, 3, 3};
        vecs[3] = '{1, 1'b0, -1, 0, -1, -1, 19, 4, 1, 1};
        vecs[4] = '{8, 1'b0, -1, 0, 10, -1, 40, 4, 8, 8};
        vecs[5] = '{64, 1'b0, -1, 0, -1, -1, 208, 4, 64, 64};
        vecs[6] = '{3, 1'b0, -1, 0, -1, 14, -1, 4, 3, 0};
        vecs[7] = '{2, 1'b0, -1, 0, -1, -1, 22, 4, 2, 2};

        rst           = 1'b0;
        start         = 1'b0;
        num_rows      = '0;
        abort         = 1'b0;
        bus.src_valid = 1'b0;
        bus.res_ready = 1'b0;
        #12;
        check_vec("reset", 0, dut_vec(), '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_vec("post reset idle", 0, dut_vec(), '0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d rows=%0d", i, vecs[i].rows));
        end

        // Out-of-range starts in IDLE are ignored.
        @(posedge clk); #1; start = 1'b1; num_rows = '0;
        @(negedge clk); check_vec("start rows=0", 0, dut_vec(), '0);
        @(posedge clk); #1; num_rows = CWV'(MAXR + 1);
        @(negedge clk); check_vec("start rows=max+1", 1, dut_vec(), '0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); check_vec("bad start ignored", 2, dut_vec(), '0);

        // Asynchronous reset in the middle of the weight shift.
        @(posedge clk); #1; start = 1'b1; num_rows = CWV'(3);
        bus.src_valid = 1'b1; bus.res_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_vec("in shift_w", 6, dut_vec(), M_BUSY | M_WBO | M_WWE);
        #2;
        rst = 1'b0;
        #1;
        check_vec("async reset", 6, dut_vec(), '0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_vec("idle after reset", k, dut_vec(), '0);
        end
        run_vec(vecs[7], "after reset rows=2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
